// File: rtl/cal_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cal_bus_arb
//  Description : Shared-bus arbiter and master mux between the CPU and the
//                cal_acc accelerator. Grants are registered (one cycle of
//                request-to-grant latency). A one-cycle GAP separates every
//                release from the next grant. Accelerator tenure is bounded
//                to MAX_BURST cycles while a CPU request is pending.
//  Ports       :
//    clk, rst_n                     clock, synchronous active-low reset
//    cpu_req/addr/wdata/write       CPU master request and bus signals
//    cpu_gnt                        CPU grant
//    acc_req/addr/wdata/write       accelerator master request and bus signals
//    arb_res                        accelerator grant
//    mem_rdata                      read data from memory/peripherals
//    bus_addr/wdata/write           shared bus (idle value 0 without grant)
//    bus_rdata                      read data returned to both masters
//    arb_busy                       either grant high
//  Revision    : 1.0  initial release
// ============================================================================
module cal_bus_arb #(
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_write,
    output logic        cpu_gnt,
    input  logic        acc_req,
    input  logic [15:0] acc_addr,
    input  logic [7:0]  acc_wdata,
    input  logic        acc_write,
    output logic        arb_res,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_write,
    output logic [7:0]  bus_rdata,
    output logic        arb_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_ACC  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    state_t           state;
    logic             last_acc;   // 1: accelerator owned the bus last
    logic [CNT_W-1:0] burst_cnt;

    logic             want_cpu;
    logic             want_acc;
    logic [CNT_W-1:0] cnt_inc;

    // Tie-break: on a simultaneous request the master that did not own the
    // bus last wins.
    always_comb begin
        want_cpu = cpu_req & (~acc_req | last_acc);
        want_acc = acc_req & (~cpu_req | ~last_acc);
    end

    // burst_cnt holds the number of completed ACC cycles; cnt_inc is the
    // count including the current one, so a preemption decision made on
    // cnt_inc ends tenure after exactly MAX_BURST granted cycles.
    always_comb begin
        cnt_inc = (burst_cnt == MAX_CNT) ? MAX_CNT : burst_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cpu_gnt   <= 1'b0;
            arb_res   <= 1'b0;
            burst_cnt <= '0;
            last_acc  <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE, S_GAP: begin
                    if (want_cpu) begin
                        state   <= S_CPU;
                        cpu_gnt <= 1'b1;
                        arb_res <= 1'b0;
                    end else if (want_acc) begin
                        state     <= S_ACC;
                        cpu_gnt   <= 1'b0;
                        arb_res   <= 1'b1;
                        burst_cnt <= '0;
                    end else begin
                        state   <= S_IDLE;
                        cpu_gnt <= 1'b0;
                        arb_res <= 1'b0;
                    end
                end
                S_CPU: begin
                    if (!cpu_req) begin
                        state    <= S_GAP;
                        cpu_gnt  <= 1'b0;
                        last_acc <= 1'b0;
                    end
                end
                S_ACC: begin
                    burst_cnt <= cnt_inc;
                    if (!acc_req || (cpu_req && cnt_inc == MAX_CNT)) begin
                        state    <= S_GAP;
                        arb_res  <= 1'b0;
                        last_acc <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cpu_gnt <= 1'b0;
                    arb_res <= 1'b0;
                end
            endcase
        end
    end

    // Bus mux driven only from the registered grants, so an ungranted
    // master's strobe can never reach the bus.
    always_comb begin
        bus_addr  = 16'h0000;
        bus_wdata = 8'h00;
        bus_write = 1'b0;
        if (cpu_gnt) begin
            bus_addr  = cpu_addr;
            bus_wdata = cpu_wdata;
            bus_write = cpu_write;
        end else if (arb_res) begin
            bus_addr  = acc_addr;
            bus_wdata = acc_wdata;
            bus_write = acc_write;
        end
    end

    assign bus_rdata = mem_rdata;
    assign arb_busy  = cpu_gnt | arb_res;

endmodule
`default_nettype wire

// File: tb/tb_cal_bus_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cal_bus_arb
//  Description : Directed self-checking bench for cal_bus_arb: reset, tie
//                break, single burst, preemption, unbounded tenure,
//                ungranted write blocking and reset during tenure.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cal_bus_arb;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_write;
    logic        cpu_gnt;
    logic        acc_req;
    logic [15:0] acc_addr;
    logic [7:0]  acc_wdata;
    logic        acc_write;
    logic        arb_res;
    logic [7:0]  mem_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_write;
    logic [7:0]  bus_rdata;
    logic        arb_busy;

    int total;
    int bad;

    cal_bus_arb #(.MAX_BURST(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_write (cpu_write),
        .cpu_gnt   (cpu_gnt),
        .acc_req   (acc_req),
        .acc_addr  (acc_addr),
        .acc_wdata (acc_wdata),
        .acc_write (acc_write),
        .arb_res   (arb_res),
        .mem_rdata (mem_rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_write (bus_write),
        .bus_rdata (bus_rdata),
        .arb_busy  (arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        cpu_req   = 1'b1;
        cpu_addr  = 16'h2222;
        cpu_wdata = 8'h33;
        cpu_write = 1'b1;
        acc_req   = 1'b1;
        acc_addr  = 16'h4444;
        acc_wdata = 8'h55;
        acc_write = 1'b1;
        mem_rdata = 8'h5A;

        // ---- reset with both requests high ----
        repeat (3) step();
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_arb_res", 32'(arb_res), 32'd0);
        chk("rst_bus_write", 32'(bus_write), 32'd0);
        chk("rst_bus_addr", 32'(bus_addr), 32'h0);
        chk("rst_busy", 32'(arb_busy), 32'd0);
        chk("rdata_pass", 32'(bus_rdata), 32'h5A);

        // release: tie goes to the CPU
        rst_n = 1'b1;
        step();
        chk("tie_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("tie_arb_res", 32'(arb_res), 32'd0);
        chk("tie_bus_addr", 32'(bus_addr), 32'h2222);
        chk("tie_bus_wdata", 32'(bus_wdata), 32'h33);
        chk("tie_busy", 32'(arb_busy), 32'd1);

        // CPU drops request; its write in the drop cycle still reaches the bus
        cpu_req = 1'b0;
        #1;
        chk("drop_fwd_write", 32'(bus_write), 32'd1);
        step();
        chk("cpu_gap_gnt", 32'(cpu_gnt), 32'd0);
        chk("cpu_gap_res", 32'(arb_res), 32'd0);
        chk("cpu_gap_write", 32'(bus_write), 32'd0);
        step();
        chk("acc_after_gap", 32'(arb_res), 32'd1);
        acc_req = 1'b0;
        cpu_write = 1'b0;
        step();
        step();
        chk("idle_state", 32'(dut.state), 32'd0);

        // ---- single accelerator burst, 10 request cycles ----
        acc_write = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            acc_req  = (i < 10);
            acc_addr = 16'h1000 + 16'(i);
            #1;
            if (i == 0) begin
                chk("burst_pre_res", 32'(arb_res), 32'd0);
                chk("burst_pre_addr", 32'(bus_addr), 32'h0);
            end else begin
                chk("burst_res", 32'(arb_res), 32'd1);
                chk("burst_addr", 32'(bus_addr), 32'h1000 + i);
            end
            step();
        end
        chk("burst_gap_state", 32'(dut.state), 32'd3);
        chk("burst_gap_res", 32'(arb_res), 32'd0);
        chk("burst_gap_write", 32'(bus_write), 32'd0);
        chk("burst_gap_addr", 32'(bus_addr), 32'h0);
        step();
        chk("burst_idle", 32'(dut.state), 32'd0);

        // ---- preemption + ungranted CPU write ----
        acc_req   = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = 16'h00F0;
        cpu_wdata = 8'hC3;
        cpu_write = 1'b1;
        step();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!arb_res) break;
            n++;
            if (n == 3) cpu_req = 1'b1;
            acc_write = n[0];
            acc_addr  = 16'hA000 + 16'(n);
            #1;
            chk("ungr_write", 32'(bus_write), 32'(n[0]));
            chk("ungr_addr", 32'(bus_addr), 32'hA000 + 32'(n));
            chk("excl", 32'(cpu_gnt & arb_res), 32'd0);
            step();
        end
        chk("preempt_len", 32'(n), 32'd16);
        chk("preempt_gap_gnt", 32'(cpu_gnt), 32'd0);
        chk("preempt_gap_res", 32'(arb_res), 32'd0);
        step();
        chk("preempt_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("preempt_cpu_addr", 32'(bus_addr), 32'h00F0);
        chk("preempt_cpu_write", 32'(bus_write), 32'd1);
        cpu_req = 1'b0;
        step();
        chk("cpu_rel_gap", 32'(cpu_gnt | arb_res), 32'd0);
        cpu_req = 1'b1;   // both request; CPU owned last, accelerator wins
        step();
        chk("acc_prio_res", 32'(arb_res), 32'd1);
        chk("acc_prio_gnt", 32'(cpu_gnt), 32'd0);
        chk("acc_prio_cnt", 32'(dut.burst_cnt), 32'd0);
        cpu_req   = 1'b0;
        cpu_write = 1'b0;
        acc_req   = 1'b0;
        step();
        step();

        // ---- no preemption: 40-cycle tenure ----
        acc_req = 1'b1;
        step();
        for (int k = 0; k < 40; k++) begin
            chk("long_res", 32'(arb_res), 32'd1);
            if (k == 20) chk("long_cnt_sat20", 32'(dut.burst_cnt), 32'd16);
            step();
        end
        chk("long_cnt_sat", 32'(dut.burst_cnt), 32'd16);
        chk("long_still_res", 32'(arb_res), 32'd1);
        acc_req = 1'b0;
        step();
        step();

        // ---- reset during accelerator tenure ----
        acc_req  = 1'b1;
        acc_addr = 16'h7777;
        step();
        repeat (4) step();
        chk("mid_res_pre", 32'(arb_res), 32'd1);
        chk("mid_cnt_pre", 32'(dut.burst_cnt), 32'd4);
        rst_n = 1'b0;
        step();
        chk("mid_rst_res", 32'(arb_res), 32'd0);
        chk("mid_rst_addr", 32'(bus_addr), 32'h0);
        chk("mid_rst_state", 32'(dut.state), 32'd0);
        chk("mid_rst_cnt", 32'(dut.burst_cnt), 32'd0);
        rst_n   = 1'b1;
        acc_req = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
